spram_wseq: RTL

- Parametrised word sequencer in front of a byte-wide single-port synchronous RAM of the spram8 family.
- Accepts N-byte word read/write requests over a req/ack handshake and serialises them into per-byte RAM cycles, little-endian.
- Sits between the eForth1 core's cell-wide data path and the 8-bit memory port, so 16/24/32-bit cells need no external byte logic.

---
 rtl/spram_pkg.sv | 18 +
 rtl/spram_wseq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/spram_pkg.sv
// Shared state encoding, default geometry and byte-lane helper for the
// spram8 word sequencer.
package spram_pkg;

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  localparam int DEF_ASZ = 17;
  localparam int DEF_DSZ = 8;
  localparam int LANE_W  = 64;

  // Bring byte lane k of a word down to the low bits; the caller keeps dsz bits.
  function automatic logic [LANE_W-1:0] lane_shift(input logic [LANE_W-1:0] w,
                                                   input int unsigned k,
                                                   input int unsigned dsz);
    return w >> (k * dsz);
  endfunction

endpackage

// File: rtl/spram_wseq.sv
// Serialises NB-byte word requests into little-endian byte cycles on a spram8 port.
// Optional byte write strobes are enabled with the SPRAM_WSTRB_EN macro.
module spram_wseq
  import spram_pkg::*;
#(
  parameter int ASZ = DEF_ASZ,
  parameter int DSZ = DEF_DSZ,
  parameter int NB  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ASZ-1:0]    addr,
  input  logic [NB*DSZ-1:0] wdata,
`ifdef SPRAM_WSTRB_EN
  input  logic [NB-1:0]     wstrb,
`endif
  output logic [NB*DSZ-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic [ASZ-1:0]    mem_ai,
  output logic [DSZ-1:0]    mem_vi,
  output logic              mem_we,
  input  logic [DSZ-1:0]    mem_vo
);

  localparam int W  = NB * DSZ;
  localparam int KW = $clog2(NB + 1);
  localparam logic [KW-1:0] K_LAST_WR = KW'(NB - 1);
  localparam logic [KW-1:0] K_LAST_RD = KW'(NB);

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d, k_inc;
  logic [ASZ-1:0]  addr_l_q, addr_l_d;
  logic [W-1:0]    wdata_l_q, wdata_l_d;
  logic [W-1:0]    shadow_q, shadow_d;
  logic [W-1:0]    rdata_q, rdata_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic [ASZ-1:0]  mem_ai_q, mem_ai_d;
  logic [DSZ-1:0]  mem_vi_q, mem_vi_d;
  logic            mem_we_q, mem_we_d;
`ifdef SPRAM_WSTRB_EN
  logic [NB-1:0]   wstrb_l_q, wstrb_l_d;
  logic [NB-1:0]   strb_sh;
`endif

  function automatic logic [DSZ-1:0] byte_of(input logic [W-1:0] w, input logic [KW-1:0] k);
    logic [LANE_W-1:0] t;
    t = lane_shift(LANE_W'(w), 32'(k), DSZ);
    return t[DSZ-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    k_inc     = k_q + 1'b1;
    addr_l_d  = addr_l_q;
    wdata_l_d = wdata_l_q;
    shadow_d  = shadow_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    busy_d    = busy_q;
    mem_ai_d  = mem_ai_q;
    mem_vi_d  = '0;
    mem_we_d  = 1'b0;
`ifdef SPRAM_WSTRB_EN
    wstrb_l_d = wstrb_l_q;
    strb_sh   = wstrb_l_q >> k_inc;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_l_d  = addr;
          wdata_l_d = wdata;
          k_d       = '0;
          busy_d    = 1'b1;
          mem_ai_d  = addr;
`ifdef SPRAM_WSTRB_EN
          wstrb_l_d = wstrb;
`endif
          // Byte 0 goes out on the accept edge so WR lasts exactly NB cycles.
          if (we) begin
            state_d  = WR;
            mem_vi_d = byte_of(wdata, '0);
`ifdef SPRAM_WSTRB_EN
            mem_we_d = wstrb[0];
`else
            mem_we_d = 1'b1;
`endif
          end else begin
            state_d = RD;
          end
        end
      end
      WR: begin
        if (k_q == K_LAST_WR) begin
          state_d = DONE;
          ack_d   = 1'b1;
        end else begin
          k_d      = k_inc;
          mem_ai_d = addr_l_q + ASZ'(k_inc);
          mem_vi_d = byte_of(wdata_l_q, k_inc);
`ifdef SPRAM_WSTRB_EN
          mem_we_d = strb_sh[0];
`else
          mem_we_d = 1'b1;
`endif
        end
      end
      RD: begin
        // RAM data lags the address by one cycle, so cycle k holds byte k-1.
        if (k_q != '0) shadow_d[(int'(k_q) - 1) * DSZ +: DSZ] = mem_vo;
        if (k_q == K_LAST_RD) begin
          state_d = DONE;
          ack_d   = 1'b1;
          rdata_d = shadow_d;
        end else begin
          k_d = k_inc;
          if (k_q != K_LAST_WR) mem_ai_d = addr_l_q + ASZ'(k_inc);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      addr_l_q  <= '0;
      wdata_l_q <= '0;
      shadow_q  <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      mem_ai_q  <= '0;
      mem_vi_q  <= '0;
      mem_we_q  <= 1'b0;
`ifdef SPRAM_WSTRB_EN
      wstrb_l_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      addr_l_q  <= addr_l_d;
      wdata_l_q <= wdata_l_d;
      shadow_q  <= shadow_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      mem_ai_q  <= mem_ai_d;
      mem_vi_q  <= mem_vi_d;
      mem_we_q  <= mem_we_d;
`ifdef SPRAM_WSTRB_EN
      wstrb_l_q <= wstrb_l_d;
`endif
    end
  end

  assign rdata  = rdata_q;
  assign ack    = ack_q;
  assign busy   = busy_q;
  assign mem_ai = mem_ai_q;
  assign mem_vi = mem_vi_q;
  assign mem_we = mem_we_q;

endmodule
